// File: rtl/ALU_pkg.sv
// ALU_pkg: operation codes shared between the controller (issuer) and the ALU.
package ALU_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_SrB  = 4'd10   // pass operand B through (LUI)
    } ALUop_t;

endpackage

// File: rtl/mc_controller.sv
// mc_controller: multicycle control unit for the riscv32i core.
// Sequences each RV32I instruction through fetch / decode / execute / memory /
// writeback states and drives the datapath muxes, write enables and ALU op.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   op, funct3, funct7b5  instruction fields IR[6:0], IR[14:12], IR[30]
//   Zero                  ALU zero flag (used only in BRANCH)
//   mem_ready             memory access completes this cycle
//   PCWrite, IRWrite      PC / IR+OldPC write enables
//   RegWrite, MemWrite    register-file / data-memory write enables
//   AdrSrc                memory address select (0 PC, 1 Result)
//   ALUSrcA, ALUSrcB      ALU operand selects
//   ResultSrc             result select (00 ALUOut, 01 Data, 10 ALUResult)
//   ImmSrc                immediate format (I,S,B,J,U = 0..4)
//   ALUControl            ALU operation
//   instr_done            pulse in the last state of each instruction
//   illegal               sticky, set once an unsupported instruction is seen
module mc_controller
    import ALU_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [2:0] ImmSrc,
    output ALUop_t     ALUControl,
    output logic       instr_done,
    output logic       illegal
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_JALR1, S_LUI, S_AUIPC,
        S_BRANCH, S_TRAP
    } state_t;

    state_t state_q, state_d;

    // Ungated write enables; the real outputs are forced low while rst_n=0.
    logic pc_write_c, ir_write_c, reg_write_c, mem_write_c, done_c;

    function automatic logic [2:0] imm_decode(input logic [6:0] o);
        case (o)
            OP_STORE:          return 3'b001;
            OP_BRANCH:         return 3'b010;
            OP_JAL:            return 3'b011;
            OP_LUI, OP_AUIPC:  return 3'b100;
            default:           return 3'b000;
        endcase
    endfunction

    function automatic ALUop_t alu_decode(input logic [2:0] f3, input logic f7b5,
                                          input logic rtype);
        case (f3)
            3'b000:  return (rtype && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // BEQ/BNE compare by subtraction; the ordered compares produce 0/1 via
    // SLT/SLTU, so the taken sense on Zero flips between the two groups.
    function automatic ALUop_t branch_alu(input logic [2:0] f3);
        case (f3[2:1])
            2'b00:   return ALU_SUB;
            2'b10:   return ALU_SLT;
            2'b11:   return ALU_SLTU;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic z);
        case (f3)
            3'b000, 3'b101, 3'b111: return z;
            3'b001, 3'b100, 3'b110: return !z;
            default:                return 1'b0;
        endcase
    endfunction

    function automatic logic branch_valid(input logic [2:0] f3);
        return f3[2:1] != 2'b01;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_write_c  = 1'b0;
        ir_write_c  = 1'b0;
        reg_write_c = 1'b0;
        mem_write_c = 1'b0;
        done_c      = 1'b0;
        AdrSrc      = 1'b0;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ResultSrc   = 2'b00;
        ALUControl  = ALU_ADD;
        ImmSrc      = imm_decode(op);

        unique case (state_q)
            S_FETCH: begin
                ir_write_c = mem_ready;
                pc_write_c = mem_ready;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_I:              state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR1;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc   = 2'b01;
                reg_write_c = 1'b1;
                done_c      = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                mem_write_c = 1'b1;
                done_c      = mem_ready;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_decode(funct3, funct7b5, 1'b1);
                state_d    = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_decode(funct3, funct7b5, 1'b0);
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                done_c      = 1'b1;
                state_d     = S_FETCH;
            end
            // PC <= ALUOut (target from DECODE or JALR1) while the ALU forms
            // OldPC+4, which ALUWB then writes to rd.
            S_JAL: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                pc_write_c = 1'b1;
                state_d    = S_ALUWB;
            end
            S_JALR1: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = S_JAL;
            end
            S_LUI: begin
                ALUSrcB    = 2'b01;
                ALUControl = ALU_SrB;
                state_d    = S_ALUWB;
            end
            S_AUIPC: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                state_d = S_ALUWB;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = branch_alu(funct3);
                done_c     = 1'b1;
                if (branch_valid(funct3)) begin
                    pc_write_c = branch_taken(funct3, Zero);
                    state_d    = S_FETCH;
                end else begin
                    state_d    = S_TRAP;
                end
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase
    end

    // The reset forces FETCH, whose enables follow mem_ready; gating with
    // rst_n keeps every enable low for the whole time reset is held.
    assign PCWrite    = rst_n & pc_write_c;
    assign IRWrite    = rst_n & ir_write_c;
    assign RegWrite   = rst_n & reg_write_c;
    assign MemWrite   = rst_n & mem_write_c;
    assign instr_done = rst_n & done_c;
    // TRAP only exits through reset, so the state itself is the sticky flag.
    assign illegal    = (state_q == S_TRAP);

endmodule

// File: tb/tb_mc_controller.sv
module tb_mc_controller;
    import ALU_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [2:0] ImmSrc;
    ALUop_t     ALUControl;
    logic       instr_done, illegal;

    mc_controller dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .instr_done(instr_done),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    // {PCWrite,IRWrite,RegWrite,MemWrite,AdrSrc,A,B,Result,ImmSrc,ALU,done,illegal}
    logic [19:0] obs;
    assign obs = {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB,
                  ResultSrc, ImmSrc, ALUControl, instr_done, illegal};

    localparam logic [2:0] IM_I = 3'd0, IM_S = 3'd1, IM_B = 3'd2, IM_J = 3'd3, IM_U = 3'd4;

    logic [19:0] exp_q[$];
    string       tag_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    // en = {PCWrite,IRWrite,RegWrite,MemWrite,AdrSrc}, fl = {instr_done,illegal}
    function automatic logic [19:0] ex(input logic [4:0] en, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] rs,
                                       input logic [2:0] imm, input ALUop_t alu,
                                       input logic [1:0] fl);
        return {en, a, b, rs, imm, alu, fl};
    endfunction

    function automatic logic [19:0] e_fetch(input logic [2:0] imm);
        return ex(5'b11000, 2'b00, 2'b10, 2'b10, imm, ALU_ADD, 2'b00);
    endfunction
    function automatic logic [19:0] e_reset(input logic [2:0] imm);
        return ex(5'b00000, 2'b00, 2'b10, 2'b10, imm, ALU_ADD, 2'b00);
    endfunction
    function automatic logic [19:0] e_decode(input logic [2:0] imm);
        return ex(5'b00000, 2'b01, 2'b01, 2'b00, imm, ALU_ADD, 2'b00);
    endfunction
    function automatic logic [19:0] e_aluwb(input logic [2:0] imm);
        return ex(5'b00100, 2'b00, 2'b00, 2'b00, imm, ALU_ADD, 2'b10);
    endfunction

    task automatic check_out();
        logic [19:0] e;
        string       t;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty observed=%b required=<entry>", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s observed=%b required=%b", t, obs, e);
            end
        end
    endtask

    // One clock cycle: inputs are already driven, push the expectation,
    // compare on the falling edge, then move to just after the next rising edge.
    task automatic cyc(input string tag, input logic [19:0] e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ir(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op = o; funct3 = f3; funct7b5 = f7;
    endtask

    initial begin
        rst_n = 1'b0; mem_ready = 1'b1; Zero = 1'b0;
        set_ir(7'b0110011, 3'b000, 1'b1);
        cyc("reset_state", e_reset(IM_I));
        rst_n = 1'b1;

        // R-type SUB
        cyc("sub_fetch",  e_fetch(IM_I));
        cyc("sub_decode", e_decode(IM_I));
        cyc("sub_execr",  ex(5'b00000, 2'b10, 2'b00, 2'b00, IM_I, ALU_SUB, 2'b00));
        cyc("sub_aluwb",  e_aluwb(IM_I));

        // Load with two wait cycles in MEMREAD
        set_ir(7'b0000011, 3'b010, 1'b0);
        cyc("lw_fetch",  e_fetch(IM_I));
        cyc("lw_decode", e_decode(IM_I));
        cyc("lw_memadr", ex(5'b00000, 2'b10, 2'b01, 2'b00, IM_I, ALU_ADD, 2'b00));
        mem_ready = 1'b0;
        cyc("lw_memread_wait1", ex(5'b00001, 2'b00, 2'b00, 2'b00, IM_I, ALU_ADD, 2'b00));
        cyc("lw_memread_wait2", ex(5'b00001, 2'b00, 2'b00, 2'b00, IM_I, ALU_ADD, 2'b00));
        mem_ready = 1'b1;
        cyc("lw_memread_rdy", ex(5'b00001, 2'b00, 2'b00, 2'b00, IM_I, ALU_ADD, 2'b00));
        cyc("lw_memwb", ex(5'b00100, 2'b00, 2'b00, 2'b01, IM_I, ALU_ADD, 2'b10));

        // BEQ, Zero=1: taken
        set_ir(7'b1100011, 3'b000, 1'b0); Zero = 1'b1;
        cyc("beq_fetch",  e_fetch(IM_B));
        cyc("beq_decode", e_decode(IM_B));
        cyc("beq_branch", ex(5'b10000, 2'b10, 2'b00, 2'b00, IM_B, ALU_SUB, 2'b10));
        // BNE, Zero=1: not taken
        set_ir(7'b1100011, 3'b001, 1'b0);
        cyc("bne_fetch",  e_fetch(IM_B));
        cyc("bne_decode", e_decode(IM_B));
        cyc("bne_branch", ex(5'b00000, 2'b10, 2'b00, 2'b00, IM_B, ALU_SUB, 2'b10));
        // BLTU, Zero=0: taken, SLTU
        set_ir(7'b1100011, 3'b110, 1'b0); Zero = 1'b0;
        cyc("bltu_fetch",  e_fetch(IM_B));
        cyc("bltu_decode", e_decode(IM_B));
        cyc("bltu_branch", ex(5'b10000, 2'b10, 2'b00, 2'b00, IM_B, ALU_SLTU, 2'b10));
        // BGE, Zero=0: not taken, SLT
        set_ir(7'b1100011, 3'b101, 1'b0);
        cyc("bge_fetch",  e_fetch(IM_B));
        cyc("bge_decode", e_decode(IM_B));
        cyc("bge_branch", ex(5'b00000, 2'b10, 2'b00, 2'b00, IM_B, ALU_SLT, 2'b10));

        // SRAI
        set_ir(7'b0010011, 3'b101, 1'b1);
        cyc("srai_fetch",  e_fetch(IM_I));
        cyc("srai_decode", e_decode(IM_I));
        cyc("srai_execi",  ex(5'b00000, 2'b10, 2'b01, 2'b00, IM_I, ALU_SRA, 2'b00));
        cyc("srai_aluwb",  e_aluwb(IM_I));
        // ADDI with funct7b5=1 must stay ADD
        set_ir(7'b0010011, 3'b000, 1'b1);
        cyc("addi_fetch",  e_fetch(IM_I));
        cyc("addi_decode", e_decode(IM_I));
        cyc("addi_execi",  ex(5'b00000, 2'b10, 2'b01, 2'b00, IM_I, ALU_ADD, 2'b00));
        cyc("addi_aluwb",  e_aluwb(IM_I));
        // LUI
        set_ir(7'b0110111, 3'b000, 1'b0);
        cyc("lui_fetch",  e_fetch(IM_U));
        cyc("lui_decode", e_decode(IM_U));
        cyc("lui_lui",    ex(5'b00000, 2'b00, 2'b01, 2'b00, IM_U, ALU_SrB, 2'b00));
        cyc("lui_aluwb",  e_aluwb(IM_U));
        // JAL
        set_ir(7'b1101111, 3'b000, 1'b0);
        cyc("jal_fetch",  e_fetch(IM_J));
        cyc("jal_decode", e_decode(IM_J));
        cyc("jal_jal",    ex(5'b10000, 2'b01, 2'b10, 2'b00, IM_J, ALU_ADD, 2'b00));
        cyc("jal_aluwb",  e_aluwb(IM_J));
        // Store, no wait
        set_ir(7'b0100011, 3'b010, 1'b0);
        cyc("sw_fetch",    e_fetch(IM_S));
        cyc("sw_decode",   e_decode(IM_S));
        cyc("sw_memadr",   ex(5'b00000, 2'b10, 2'b01, 2'b00, IM_S, ALU_ADD, 2'b00));
        cyc("sw_memwrite", ex(5'b00011, 2'b00, 2'b00, 2'b00, IM_S, ALU_ADD, 2'b10));

        // Unsupported opcode -> TRAP, held until reset
        set_ir(7'b1111111, 3'b000, 1'b0);
        cyc("trap_fetch",  e_fetch(IM_I));
        cyc("trap_decode", e_decode(IM_I));
        for (int i = 0; i < 20; i++)
            cyc($sformatf("trap_hold%0d", i),
                ex(5'b00000, 2'b00, 2'b00, 2'b00, IM_I, ALU_ADD, 2'b01));
        rst_n = 1'b0;
        cyc("trap_reset", e_reset(IM_I));
        rst_n = 1'b1;

        // Reset during a stalled MEMWRITE
        set_ir(7'b0100011, 3'b010, 1'b0);
        cyc("swr_fetch",  e_fetch(IM_S));
        cyc("swr_decode", e_decode(IM_S));
        cyc("swr_memadr", ex(5'b00000, 2'b10, 2'b01, 2'b00, IM_S, ALU_ADD, 2'b00));
        mem_ready = 1'b0;
        cyc("swr_memwrite_wait", ex(5'b00011, 2'b00, 2'b00, 2'b00, IM_S, ALU_ADD, 2'b00));
        rst_n = 1'b0;
        cyc("swr_reset_midwrite", e_reset(IM_S));
        rst_n = 1'b1; mem_ready = 1'b1;
        set_ir(7'b0110011, 3'b000, 1'b0);
        cyc("post_reset_fetch",  e_fetch(IM_I));
        cyc("post_reset_decode", e_decode(IM_I));
        cyc("post_reset_execr",  ex(5'b00000, 2'b10, 2'b00, 2'b00, IM_I, ALU_ADD, 2'b00));
        cyc("post_reset_aluwb",  e_aluwb(IM_I));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
